// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, types and GF(2^8) helpers
package aes_pkg;

    localparam int AES128_ROUNDS = 10;

    // Index 0 is unused; the schedule starts at round 1.
    localparam logic [7:0] RCON [0:AES128_ROUNDS] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } aes_state_t;

    typedef logic [127:0] rk_bank_t [0:AES128_ROUNDS];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational forward AES S-box
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] a,
    output logic [7:0] y
);

    logic [7:0] p2, p4, p8, p16, p32, p64, p128;
    logic [7:0] inv;

    // Multiplicative inverse as a^254 (maps 0 to 0), then the affine transform.
    assign p2   = gf_mul(a, a);
    assign p4   = gf_mul(p2, p2);
    assign p8   = gf_mul(p4, p4);
    assign p16  = gf_mul(p8, p8);
    assign p32  = gf_mul(p16, p16);
    assign p64  = gf_mul(p32, p32);
    assign p128 = gf_mul(p64, p64);
    assign inv  = gf_mul(gf_mul(gf_mul(p2, p4), gf_mul(p8, p16)),
                         gf_mul(gf_mul(p32, p64), p128));

    assign y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;

endmodule

// File: rtl/aes128_key_expand.sv
// rtl/aes128_key_expand.sv - iterative AES-128 key schedule with random-access round-key bank
module aes128_key_expand
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [3:0]   rk_sel,
    output logic         finish,
    output logic [127:0] rk_out
);

    aes_state_t state, state_nxt;
    logic [3:0] round;
    rk_bank_t   rk;

    logic [127:0] prev;
    logic [7:0]   rcon;
    logic [31:0]  rot, sub, t;
    logic [31:0]  n0, n1, n2, n3;

    always_comb begin
        prev = '0;
        rcon = '0;
        for (int i = 1; i <= AES128_ROUNDS; i++) begin
            if (round == 4'(i)) begin
                prev = rk[i-1];
                rcon = RCON[i];
            end
        end
    end

    assign rot = {prev[103:96], prev[127:104]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .a(rot[8*g +: 8]),
            .y(sub[8*g +: 8])
        );
    end

    assign t  = sub ^ {24'h0, rcon};
    assign n0 = prev[31:0]   ^ t;
    assign n1 = prev[63:32]  ^ n0;
    assign n2 = prev[95:64]  ^ n1;
    assign n3 = prev[127:96] ^ n2;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = EXPAND;
            EXPAND: begin
                if (!start)                             state_nxt = IDLE;
                else if (round == 4'(AES128_ROUNDS))    state_nxt = DONE;
            end
            DONE:    if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            round <= '0;
            for (int i = 0; i <= AES128_ROUNDS; i++) rk[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        rk[0] <= key;
                        round <= 4'd1;
                    end
                end
                EXPAND: begin
                    if (start) begin
                        for (int i = 1; i <= AES128_ROUNDS; i++) begin
                            if (round == 4'(i)) rk[i] <= {n3, n2, n1, n0};
                        end
                        round <= round + 4'd1;
                    end else begin
                        round <= '0;
                    end
                end
                DONE: begin
                    if (!start) round <= '0;
                end
                default: round <= '0;
            endcase
        end
    end

    assign finish = (state == DONE);

    // Selects beyond rk10 fall through to zero.
    always_comb begin
        rk_out = '0;
        for (int i = 0; i <= AES128_ROUNDS; i++) begin
            if (rk_sel == 4'(i)) rk_out = rk[i];
        end
    end

endmodule

// File: tb/tb_aes128_key_expand.sv
// tb/tb_aes128_key_expand.sv - scoreboard bench for aes128_key_expand
module tb_aes128_key_expand;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic [3:0]   rk_sel;
    logic         finish;
    logic [127:0] rk_out;

    aes128_key_expand dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .key   (key),
        .rk_sel(rk_sel),
        .finish(finish),
        .rk_out(rk_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   sel;
        logic [127:0] val;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int checks = 0;
    int errors = 0;

    logic [7:0] gexp [0:255];
    logic [7:0] glog [0:255];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_xtime(input logic [7:0] a);
        return a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    // Reference S-box via log/antilog tables over generator 3.
    function automatic logic [7:0] m_sbox(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] s;
        inv = (x == 8'h00) ? 8'h00 : gexp[(255 - int'(glog[x])) % 255];
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] m_next(input logic [127:0] p, input logic [7:0] rc);
        logic [31:0] w [0:3];
        logic [31:0] r, t;
        for (int i = 0; i < 4; i++) w[i] = p[32*i +: 32];
        r = {w[3][7:0], w[3][31:8]};
        for (int i = 0; i < 4; i++) t[8*i +: 8] = m_sbox(r[8*i +: 8]);
        t[7:0] = t[7:0] ^ rc;
        w[0] = w[0] ^ t;
        w[1] = w[1] ^ w[0];
        w[2] = w[2] ^ w[1];
        w[3] = w[3] ^ w[2];
        return {w[3], w[2], w[1], w[0]};
    endfunction

    task automatic push_model(input logic [127:0] k);
        logic [127:0] r;
        logic [7:0]   rc;
        r  = k;
        rc = 8'h01;
        sb_q.push_back('{4'd0, r});
        for (int i = 1; i <= 10; i++) begin
            r = m_next(r, rc);
            sb_q.push_back('{4'(i), r});
            rc = m_xtime(rc);
        end
        sb_q.push_back('{4'd11, 128'h0});
        sb_q.push_back('{4'd15, 128'h0});
    endtask

    task automatic drain();
        sb_entry_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            rk_sel = e.sel;
            #1;
            check($sformatf("rk%0d", e.sel), rk_out, e.val);
        end
    endtask

    // Counts rising edges (continuing from c0) until finish is seen, bounded.
    task automatic wait_finish(input int c0, output int lat);
        lat = 0;
        for (int c = c0 + 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (finish) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic launch(input logic [127:0] k);
        @(negedge clk);
        key   = k;
        start = 1'b1;
    endtask

    task automatic drop_start();
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k_fips, k2, k3;
        int lat;
        logic saw_fin;

        gexp[0] = 8'h01;
        for (int i = 0; i < 255; i++) begin
            glog[gexp[i]] = 8'(i);
            gexp[i+1] = gexp[i] ^ m_xtime(gexp[i]);
        end
        glog[0] = 8'h00;

        k_fips = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
        k2     = 128'h0f0e0d0c0b0a09080706050403020100;
        k3     = {$urandom, $urandom, $urandom, $urandom};

        rst    = 1'b1;
        start  = 1'b0;
        key    = '0;
        rk_sel = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_finish", {127'h0, finish}, 128'h0);
        check("rst_rk0", rk_out, 128'h0);
        @(negedge clk);
        rst = 1'b0;

        // FIPS-197 vector
        launch(k_fips);
        push_model(k_fips);
        sb_q.push_back('{4'd1,  128'h05766c2a3939a323b12c548817fefaa0});
        sb_q.push_back('{4'd10, 128'ha60c63b6c80c3fe18925eec9a8f914d0});
        wait_finish(0, lat);
        check("fips_latency", 128'(lat), 128'd11);
        drain();

        // Handshake: finish falls one edge after start low; rerun with new key,
        // which is also scrambled mid-expansion to prove it was sampled once.
        drop_start();
        @(posedge clk);
        #1;
        check("finish_fall", {127'h0, finish}, 128'h0);
        launch(k2);
        push_model(k2);
        repeat (3) @(posedge clk);
        #1;
        key = {$urandom, $urandom, $urandom, $urandom};
        wait_finish(3, lat);
        check("rerun_latency", 128'(lat), 128'd11);
        drain();

        // Abort during expansion
        drop_start();
        launch(k3);
        repeat (5) @(posedge clk);
        drop_start();
        saw_fin = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            saw_fin = saw_fin | finish;
        end
        check("abort_no_finish", {127'h0, saw_fin}, 128'h0);
        launch(k3);
        push_model(k3);
        wait_finish(0, lat);
        check("abort_restart_latency", 128'(lat), 128'd11);
        drain();

        // Asynchronous reset between edges mid-expansion
        drop_start();
        launch(k_fips);
        repeat (4) @(posedge clk);
        #2;
        rst    = 1'b1;
        rk_sel = 4'd0;
        #1;
        check("async_rst_finish", {127'h0, finish}, 128'h0);
        check("async_rst_rk0", rk_out, 128'h0);
        rk_sel = 4'd1;
        #1;
        check("async_rst_rk1", rk_out, 128'h0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;

        // Recovery after reset
        launch(k2);
        push_model(k2);
        wait_finish(0, lat);
        check("post_rst_latency", 128'(lat), 128'd11);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
